// File: rtl/issue_scheduler_int_pkg.sv
// Shared sizing constants for the integer issue scheduler slice.
package issue_scheduler_int_pkg;
  localparam int unsigned IQ_INT_SIZE     = 16;
  localparam int unsigned ISSUE_WIDTH_INT = 3;
  localparam int unsigned DISPATCH_WIDTH  = 4;
endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the integer issue queue: older[i][j]=1 means slot i was dispatched before slot j.
// Applies alloc/free updates and returns the oldest eligible slot per pipe.
module iq_age_matrix #(
  parameter int unsigned IQ_SIZE        = issue_scheduler_int_pkg::IQ_INT_SIZE,
  parameter int unsigned ISSUE_WIDTH    = issue_scheduler_int_pkg::ISSUE_WIDTH_INT,
  parameter int unsigned DISPATCH_WIDTH = issue_scheduler_int_pkg::DISPATCH_WIDTH,
  localparam int unsigned IDX_W         = $clog2(IQ_SIZE)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [IQ_SIZE-1:0]              keep,
  input  logic [DISPATCH_WIDTH-1:0]       alloc_acc,
  input  logic [DISPATCH_WIDTH*IDX_W-1:0] alloc_slot,
  input  logic [ISSUE_WIDTH*IQ_SIZE-1:0]  pipe_req,
  output logic [ISSUE_WIDTH*IQ_SIZE-1:0]  pipe_sel
);
  import issue_scheduler_int_pkg::*;

  logic [IQ_SIZE-1:0][IQ_SIZE-1:0] older;
  logic [IQ_SIZE-1:0][IQ_SIZE-1:0] older_nxt;
  logic [IQ_SIZE-1:0]              lower;
  logic [IQ_SIZE-1:0]              req;
  logic [IQ_SIZE-1:0]              sel;
  logic [IQ_SIZE-1:0]              taken;
  logic [IDX_W-1:0]                s;
  logic                            found;
  logic                            blocked;

  // Lanes are applied in order; each new slot's column is written after all row
  // clears of lower lanes, so lower lane = older without a second pass.
  always_comb begin
    older_nxt = older;
    lower     = '0;
    s         = '0;
    for (int unsigned i = 0; i < IQ_SIZE; i++) begin
      for (int unsigned j = 0; j < IQ_SIZE; j++) begin
        if (!(keep[i] && keep[j])) older_nxt[i][j] = 1'b0;
      end
    end
    for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
      if (alloc_acc[l]) begin
        s            = alloc_slot[l*IDX_W +: IDX_W];
        older_nxt[s] = '0;
        for (int unsigned j = 0; j < IQ_SIZE; j++) begin
          older_nxt[j][s] = keep[j] | lower[j];
        end
        lower[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      older <= older_nxt;
    end
  end

  always_comb begin
    pipe_sel = '0;
    taken    = '0;
    req      = '0;
    sel      = '0;
    found    = 1'b0;
    blocked  = 1'b0;
    for (int unsigned p = 0; p < ISSUE_WIDTH; p++) begin
      req   = pipe_req[p*IQ_SIZE +: IQ_SIZE] & ~taken;
      sel   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < IQ_SIZE; i++) begin
        blocked = 1'b0;
        for (int unsigned j = 0; j < IQ_SIZE; j++) begin
          blocked = blocked | (req[j] & older[j][i]);
        end
        if (req[i] && !blocked && !found) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
      pipe_sel[p*IQ_SIZE +: IQ_SIZE] = sel;
      taken = taken | sel;
    end
  end
endmodule

// File: rtl/issue_scheduler_int.sv
// Integer issue queue select/occupancy controller: oldest-first grant per pipe,
// occupancy and free-slot tracking, registered full flag and sticky alloc error.
module issue_scheduler_int #(
  parameter int unsigned IQ_SIZE        = issue_scheduler_int_pkg::IQ_INT_SIZE,
  parameter int unsigned ISSUE_WIDTH    = issue_scheduler_int_pkg::ISSUE_WIDTH_INT,
  parameter int unsigned DISPATCH_WIDTH = issue_scheduler_int_pkg::DISPATCH_WIDTH,
  localparam int unsigned IDX_W         = $clog2(IQ_SIZE)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [DISPATCH_WIDTH-1:0]       alloc_valid,
  input  logic [DISPATCH_WIDTH*IDX_W-1:0] alloc_slot,
  input  logic [IQ_SIZE-1:0]              slot_ready,
  input  logic [IQ_SIZE*ISSUE_WIDTH-1:0]  slot_pipe_mask,
  input  logic [ISSUE_WIDTH-1:0]          ex_full,
  output logic [IQ_SIZE-1:0]              slot_grant,
  output logic [ISSUE_WIDTH-1:0]          issue_valid,
  output logic [ISSUE_WIDTH*IDX_W-1:0]    issue_slot,
  output logic [IDX_W:0]                  free_count,
  output logic                            iq_int_full,
  output logic                            alloc_err
);
  import issue_scheduler_int_pkg::*;

  logic [IQ_SIZE-1:0]                  occupied;
  logic [IQ_SIZE-1:0]                  cand;
  logic [IQ_SIZE-1:0]                  keep;
  logic [IQ_SIZE-1:0]                  alloc_vec;
  logic [DISPATCH_WIDTH-1:0]           alloc_acc;
  logic                                alloc_bad;
  logic [IDX_W-1:0]                    lane_slot;
  logic [ISSUE_WIDTH-1:0][IQ_SIZE-1:0] pipe_req;
  logic [ISSUE_WIDTH-1:0][IQ_SIZE-1:0] pipe_sel;
  logic [IDX_W:0]                      acc_cnt;
  logic [IDX_W:0]                      grant_cnt;
  logic [IDX_W:0]                      free_nxt;

  always_comb begin
    cand     = occupied & slot_ready;
    pipe_req = '0;
    for (int unsigned p = 0; p < ISSUE_WIDTH; p++) begin
      for (int unsigned i = 0; i < IQ_SIZE; i++) begin
        pipe_req[p][i] = cand[i] & slot_pipe_mask[i*ISSUE_WIDTH + p] & ~ex_full[p];
      end
    end
  end

  iq_age_matrix #(
    .IQ_SIZE        (IQ_SIZE),
    .ISSUE_WIDTH    (ISSUE_WIDTH),
    .DISPATCH_WIDTH (DISPATCH_WIDTH)
  ) u_age_matrix (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .keep       (keep),
    .alloc_acc  (alloc_acc),
    .alloc_slot (alloc_slot),
    .pipe_req   (pipe_req),
    .pipe_sel   (pipe_sel)
  );

  always_comb begin
    slot_grant  = '0;
    issue_valid = '0;
    issue_slot  = '0;
    for (int unsigned p = 0; p < ISSUE_WIDTH; p++) begin
      slot_grant     = slot_grant | pipe_sel[p];
      issue_valid[p] = |pipe_sel[p];
      for (int unsigned i = 0; i < IQ_SIZE; i++) begin
        if (pipe_sel[p][i]) issue_slot[p*IDX_W +: IDX_W] = IDX_W'(i);
      end
    end
    keep = occupied & ~slot_grant;
  end

  // A slot granted this cycle is still busy for alloc; duplicate lanes lose to the lower lane.
  always_comb begin
    alloc_acc = '0;
    alloc_vec = '0;
    alloc_bad = 1'b0;
    lane_slot = '0;
    for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
      lane_slot = alloc_slot[l*IDX_W +: IDX_W];
      if (alloc_valid[l]) begin
        if (!occupied[lane_slot] && !slot_grant[lane_slot] && !alloc_vec[lane_slot]) begin
          alloc_acc[l]         = 1'b1;
          alloc_vec[lane_slot] = 1'b1;
        end else begin
          alloc_bad = 1'b1;
        end
      end
    end
  end

  always_comb begin
    acc_cnt   = '0;
    grant_cnt = '0;
    for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
      acc_cnt = acc_cnt + (IDX_W+1)'(alloc_acc[l]);
    end
    for (int unsigned i = 0; i < IQ_SIZE; i++) begin
      grant_cnt = grant_cnt + (IDX_W+1)'(slot_grant[i]);
    end
    free_nxt = free_count - acc_cnt + grant_cnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupied    <= '0;
      free_count  <= (IDX_W+1)'(IQ_SIZE);
      iq_int_full <= 1'b0;
      alloc_err   <= 1'b0;
    end else begin
      alloc_err <= alloc_err | alloc_bad;
      if (flush) begin
        occupied    <= '0;
        free_count  <= (IDX_W+1)'(IQ_SIZE);
        iq_int_full <= 1'b0;
      end else begin
        occupied    <= keep | alloc_vec;
        free_count  <= free_nxt;
        iq_int_full <= (free_nxt < (IDX_W+1)'(DISPATCH_WIDTH));
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler_int.sv
// Bench for issue_scheduler_int: directed scenarios plus random traffic against a
// dispatch-stamp reference model (oldest = smallest stamp).
module tb_issue_scheduler_int;
  localparam int IQ = 16;
  localparam int IW = 3;
  localparam int DW = 4;
  localparam int XW = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           flush;
  logic [DW-1:0]  alloc_valid;
  logic [DW*XW-1:0] alloc_slot;
  logic [IQ-1:0]  slot_ready;
  logic [IQ*IW-1:0] slot_pipe_mask;
  logic [IW-1:0]  ex_full;
  logic [IQ-1:0]  slot_grant;
  logic [IW-1:0]  issue_valid;
  logic [IW*XW-1:0] issue_slot;
  logic [XW:0]    free_count;
  logic           iq_int_full;
  logic           alloc_err;

  always #5 clock = ~clock;

  issue_scheduler_int #(
    .IQ_SIZE        (IQ),
    .ISSUE_WIDTH    (IW),
    .DISPATCH_WIDTH (DW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_slot     (alloc_slot),
    .slot_ready     (slot_ready),
    .slot_pipe_mask (slot_pipe_mask),
    .ex_full        (ex_full),
    .slot_grant     (slot_grant),
    .issue_valid    (issue_valid),
    .issue_slot     (issue_slot),
    .free_count     (free_count),
    .iq_int_full    (iq_int_full),
    .alloc_err      (alloc_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [IQ-1:0]    m_occ;
  int unsigned      m_stamp [IQ];
  int unsigned      m_seq;
  logic             m_err;
  int               m_free;
  logic             m_full;

  logic [IW-1:0]    cap_valid;
  logic [IW*XW-1:0] cap_slot;
  logic [IQ-1:0]    cap_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_slot  = '0;
    slot_ready  = '0;
    ex_full     = '0;
  endtask

  task automatic set_mask_all(input logic [IW-1:0] m);
    for (int i = 0; i < IQ; i++) slot_pipe_mask[i*IW +: IW] = m;
  endtask

  task automatic model_free();
    m_free = 0;
    for (int i = 0; i < IQ; i++) if (!m_occ[i]) m_free++;
    m_full = (m_free < DW);
  endtask

  // Inputs are already applied at posedge+1; checks grants, advances model across one edge.
  task automatic step();
    logic [IQ-1:0]    eg;
    logic [IQ-1:0]    acc;
    logic [IW-1:0]    ev;
    logic [IW*XW-1:0] es;
    int best;
    int s;
    #1;
    eg = '0; ev = '0; es = '0;
    for (int p = 0; p < IW; p++) begin
      best = -1;
      if (!ex_full[p]) begin
        for (int i = 0; i < IQ; i++) begin
          if (m_occ[i] && slot_ready[i] && slot_pipe_mask[i*IW + p] && !eg[i]) begin
            if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
          end
        end
      end
      if (best >= 0) begin
        ev[p] = 1'b1;
        es[p*XW +: XW] = XW'(best);
        eg[best] = 1'b1;
      end
    end
    cap_valid = issue_valid;
    cap_slot  = issue_slot;
    cap_grant = slot_grant;
    chk("issue_valid", 32'(issue_valid), 32'(ev));
    chk("issue_slot",  32'(issue_slot),  32'(es));
    chk("slot_grant",  32'(slot_grant),  32'(eg));
    acc = '0;
    for (int l = 0; l < DW; l++) begin
      if (alloc_valid[l]) begin
        s = int'(alloc_slot[l*XW +: XW]);
        if (m_occ[s] || eg[s] || acc[s]) begin
          m_err = 1'b1;
        end else begin
          acc[s] = 1'b1;
          m_stamp[s] = m_seq;
          m_seq++;
        end
      end
    end
    if (flush) m_occ = '0;
    else       m_occ = (m_occ & ~eg) | acc;
    model_free();
    @(posedge clock);
    #1;
    chk("free_count",  32'(free_count),  32'(m_free));
    chk("iq_int_full", 32'(iq_int_full), 32'(m_full));
    chk("alloc_err",   32'(alloc_err),   32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    #2;
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_slot_grant",  32'(slot_grant),  32'd0);
    chk("rst_free_count",  32'(free_count),  32'd16);
    chk("rst_full",        32'(iq_int_full), 32'd0);
    chk("rst_alloc_err",   32'(alloc_err),   32'd0);
    m_occ = '0;
    m_err = 1'b0;
    m_seq = 0;
    model_free();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IQ-1:0] used;
    int s;
    idle();
    slot_pipe_mask = '0;
    #2;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    step();
    chk("idle_issue_valid", 32'(cap_valid), 32'd0);
    chk("idle_free_count",  32'(free_count), 32'd16);

    // Age order on a single pipe.
    set_mask_all(3'b001);
    alloc_valid = 4'b0001; alloc_slot[3:0] = 4'd5; step();
    alloc_slot[3:0] = 4'd2; step();
    alloc_valid = '0;
    slot_ready = '0; slot_ready[5] = 1'b1; slot_ready[2] = 1'b1;
    step();
    chk("age_first_valid", 32'(cap_valid), 32'b001);
    chk("age_first_slot",  32'(cap_slot[3:0]), 32'd5);
    step();
    chk("age_second_slot", 32'(cap_slot[3:0]), 32'd2);
    slot_ready = '0;
    step();
    chk("age_free_back", 32'(free_count), 32'd16);

    // Same-cycle lanes: lower lane is older.
    set_mask_all(3'b111);
    alloc_valid = 4'b0011; alloc_slot = 16'h0019; step();
    alloc_valid = '0;
    slot_ready[9] = 1'b1; slot_ready[1] = 1'b1;
    step();
    chk("lanes_valid", 32'(cap_valid), 32'b011);
    chk("lanes_slot",  32'(cap_slot),  32'h019);
    slot_ready = '0;
    step();

    // Backpressure on pipe 0.
    set_mask_all(3'b001);
    alloc_valid = 4'b0001; alloc_slot[3:0] = 4'd3; step();
    alloc_valid = '0;
    slot_ready[3] = 1'b1;
    ex_full = 3'b001;
    repeat (3) begin
      step();
      chk("bp_hold_valid", 32'(cap_valid), 32'd0);
      chk("bp_hold_free",  32'(free_count), 32'd15);
    end
    ex_full = '0;
    step();
    chk("bp_issue_valid", 32'(cap_valid), 32'b001);
    chk("bp_issue_slot",  32'(cap_slot[3:0]), 32'd3);
    slot_ready = '0;

    // Fill to 13 occupied.
    for (int c = 0; c < 4; c++) begin
      alloc_valid = (c < 3) ? 4'hF : 4'h1;
      for (int l = 0; l < DW; l++) alloc_slot[l*XW +: XW] = XW'(c*4 + l);
      step();
    end
    chk("fill_free", 32'(free_count), 32'd3);
    chk("fill_full", 32'(iq_int_full), 32'd1);
    alloc_valid = '0;
    slot_ready[0] = 1'b1;
    step();
    chk("fill_grant_free", 32'(free_count), 32'd4);
    chk("fill_grant_full", 32'(iq_int_full), 32'd0);
    slot_ready = '0;

    // Flush overriding a same-cycle alloc and grant.
    flush = 1'b1; step(); flush = 1'b0;
    alloc_valid = 4'hF; alloc_slot = 16'h3210; step();
    alloc_valid = 4'h3; alloc_slot = 16'h0054; step();
    set_mask_all(3'b111);
    flush = 1'b1;
    alloc_valid = 4'h1; alloc_slot = 16'h000A;
    slot_ready[0] = 1'b1;
    step();
    chk("flush_grant_driven", 32'(cap_valid), 32'b001);
    chk("flush_free", 32'(free_count), 32'd16);
    chk("flush_full", 32'(iq_int_full), 32'd0);
    flush = 1'b0; alloc_valid = '0; slot_ready = '1;
    step();
    chk("flush_nothing_issues", 32'(cap_valid), 32'd0);
    slot_ready = '0;
    alloc_valid = 4'h1; alloc_slot = 16'h0007; step();
    chk("alloc_ok_no_err", 32'(alloc_err), 32'd0);
    step();
    chk("alloc_occupied_err", 32'(alloc_err), 32'd1);
    idle();
    do_reset();

    // Random traffic.
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 149) do_reset();
      flush = ($urandom_range(0, 49) == 0);
      slot_ready = IQ'($urandom);
      for (int i = 0; i < IQ; i++) slot_pipe_mask[i*IW +: IW] = IW'($urandom);
      for (int p = 0; p < IW; p++) ex_full[p] = ($urandom_range(0, 3) == 0);
      alloc_valid = '0;
      alloc_slot  = '0;
      used = '0;
      for (int l = 0; l < DW; l++) begin
        if ($urandom_range(0, 2) != 0) begin
          s = $urandom_range(0, IQ-1);
          if (!flush && (it % 150) > 100 && $urandom_range(0, 19) == 0) begin
            alloc_valid[l] = 1'b1;
            alloc_slot[l*XW +: XW] = XW'(s);
          end else begin
            for (int k = 0; k < IQ; k++) begin
              if (!alloc_valid[l] && !m_occ[(s + k) % IQ] && !used[(s + k) % IQ]) begin
                alloc_valid[l] = 1'b1;
                alloc_slot[l*XW +: XW] = XW'((s + k) % IQ);
                used[(s + k) % IQ] = 1'b1;
              end
            end
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
